// File: rtl/bsg_swap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_swap_pkg
// Purpose  : Shared definitions for the swap-serializer slice. Holds the
//            three-state encoding used by the serializer FSM.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bsg_swap_pkg;

  // Serializer occupancy: no word, first half showing, second half showing.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_e;

endpackage : bsg_swap_pkg
`default_nettype wire

// File: rtl/bsg_swap_serialize_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_swap_serialize_if
// Purpose  : Handshake bundle between an upstream word producer, the swap
//            serializer and a downstream half-word consumer.
// Signals  : v_i/data_i/swap_i  - word offered by upstream
//            ready_o            - serializer can take the word this cycle
//            v_o/data_o/last_o  - half-word presented downstream
//            yumi_i             - downstream takes the half this cycle
// Modports : slave  - serializer side
//            master - producer/consumer (environment) side
// Revision : 1.0 - initial release
// ============================================================================
interface bsg_swap_serialize_if #(
  parameter int width_p = 32
);

  logic                   v_i;
  logic [width_p-1:0]     data_i;
  logic                   swap_i;
  logic                   ready_o;
  logic                   v_o;
  logic [width_p/2-1:0]   data_o;
  logic                   last_o;
  logic                   yumi_i;

  modport slave (
    input  v_i, data_i, swap_i, yumi_i,
    output ready_o, v_o, data_o, last_o
  );

  modport master (
    output v_i, data_i, swap_i, yumi_i,
    input  ready_o, v_o, data_o, last_o
  );

endinterface : bsg_swap_serialize_if
`default_nettype wire

// File: rtl/bsg_swap.sv
`default_nettype none
// ============================================================================
// Module   : bsg_swap
// Purpose  : Purely combinational half-swap. With swap_i=1 the upper and
//            lower halves of data_i exchange places; otherwise pass-through.
// Ports    : data_i [width_p-1:0] - word in
//            swap_i               - exchange halves when 1
//            data_o [width_p-1:0] - word out
// Revision : 1.0 - initial release
// ============================================================================
module bsg_swap #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] data_i,
  input  logic               swap_i,
  output logic [width_p-1:0] data_o
);

  localparam int half_lp = width_p / 2;

  assign data_o = swap_i ? {data_i[half_lp-1:0], data_i[width_p-1:half_lp]}
                         : data_i;

endmodule : bsg_swap
`default_nettype wire

// File: rtl/bsg_swap_serialize.sv
`default_nettype none
// ============================================================================
// Module   : bsg_swap_serialize
// Purpose  : Accepts a width_p-bit word with a half-order select, then emits
//            it as two width_p/2-bit halves (low half of the optionally
//            swapped word first, last_o flagging the second half).
// Ports    : clk_i   - clock, rising edge
//            reset_i - synchronous active-high reset
//            io      - bsg_swap_serialize_if.slave handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
module bsg_swap_serialize
  import bsg_swap_pkg::*;
#(
  parameter int width_p = 32   // even, >= 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bsg_swap_serialize_if.slave   io
);

  localparam int half_lp = width_p / 2;

  state_e               state_q, state_d;
  logic [width_p-1:0]   word_q;
  logic                 swap_q;
  logic [width_p-1:0]   swapped;
  logic [half_lp-1:0]   half_sel;
  logic                 ready;
  logic                 accept;
  logic                 valid;

  // A new word fits when nothing is held, or when the last half of the
  // current word leaves this very cycle (back-to-back). This is the only
  // combinational input-to-output path.
  always_comb begin
    ready = 1'b0;
    if (!reset_i) begin
      case (state_q)
        EMPTY:   ready = 1'b1;
        SECOND:  ready = io.yumi_i;
        default: ready = 1'b0;
      endcase
    end
  end

  assign accept = io.v_i & ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept)    state_d = FIRST;
      FIRST:   if (io.yumi_i) state_d = SECOND;
      SECOND:  if (io.yumi_i) state_d = accept ? FIRST : EMPTY;
      default:                state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      word_q  <= '0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q <= io.data_i;
        swap_q <= io.swap_i;
      end
    end
  end

  // Swap works only on registered copies, so later swap_i changes cannot
  // disturb a word already in flight.
  bsg_swap #(
    .width_p (width_p)
  ) u_swap (
    .data_i  (word_q),
    .swap_i  (swap_q),
    .data_o  (swapped)
  );

  assign half_sel = (state_q == SECOND) ? swapped[width_p-1:half_lp]
                                        : swapped[half_lp-1:0];

  assign valid      = (state_q == FIRST) || (state_q == SECOND);
  assign io.ready_o = ready;
  assign io.v_o     = valid;
  assign io.last_o  = (state_q == SECOND);
  // Force zero when idle so stale word contents never leak out.
  assign io.data_o  = valid ? half_sel : '0;

endmodule : bsg_swap_serialize
`default_nettype wire

// File: tb/tb_bsg_swap_serialize.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_swap_serialize
// Purpose  : Self-checking bench for bsg_swap_serialize. A driver issues
//            words and pushes the expected halves into a scoreboard queue;
//            a monitor compares every presented half against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_swap_serialize;

  localparam int W = 32;
  localparam int H = W / 2;

  typedef struct {
    logic [H-1:0] d;
    logic         last;
  } half_t;

  logic clk;
  logic reset_i;

  bsg_swap_serialize_if #(.width_p(W)) bus ();

  bsg_swap_serialize #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  half_t        q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           chk_en   = 0;
  bit           pend_v   = 0;
  logic [W-1:0] pend_d;
  logic         pend_s;
  bit           prev_rst = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: low half of the (optionally) reordered word first, then high.
  task automatic push_word(input logic [W-1:0] w, input logic s);
    half_t a, b;
    logic [H-1:0] upper, lower;
    upper = w[W-1:H];
    lower = w[H-1:0];
    a.d = s ? upper : lower; a.last = 1'b0;
    b.d = s ? lower : upper; b.last = 1'b1;
    q.push_back(a);
    q.push_back(b);
  endtask

  // One clock of stimulus. Inputs change 1 time unit after the edge;
  // the accept decision is taken once combinational ready has settled.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] d,
                       input logic s, input logic y, output bit acc);
    @(posedge clk);
    #1;
    if (prev_rst) begin
      q.delete();
      pend_v = 0;
    end
    if (pend_v) begin
      push_word(pend_d, pend_s);
      pend_v = 0;
    end
    chk_en     = 1;
    reset_i    = rst;
    bus.v_i    = v;
    bus.data_i = d;
    bus.swap_i = s;
    bus.yumi_i = y && (q.size() != 0);
    #3;
    acc = !rst && v && bus.ready_o;
    if (acc) begin
      pend_v = 1;
      pend_d = d;
      pend_s = s;
    end
    prev_rst = rst;
  endtask

  // Monitor: compares the presented half with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready_o", {31'd0, bus.ready_o},
            {31'd0, !reset_i && (q.size() == 0 || (q.size() == 1 && bus.yumi_i))});
        chk("v_o", {31'd0, bus.v_o}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
          chk("data_o", {16'd0, bus.data_o}, {16'd0, q[0].d});
          chk("last_o", {31'd0, bus.last_o}, {31'd0, q[0].last});
          if (bus.yumi_i) void'(q.pop_front());
        end else begin
          chk("data_o_idle", {16'd0, bus.data_o}, 32'd0);
          chk("last_o_idle", {31'd0, bus.last_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    bit           acc;
    logic [W-1:0] words[2];
    int           idx;
    logic [W-1:0] rw;
    logic         rs;
    bit           hold;

    reset_i    = 1'b1;
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    bus.swap_i = 1'b0;
    bus.yumi_i = 1'b0;

    // Reset held for a few cycles.
    repeat (3) cycle(1, 0, '0, 0, 0, acc);

    // No swap: 0xAAAA5555 -> 0x5555, 0xAAAA.
    cycle(0, 1, 32'hAAAA5555, 0, 1, acc);
    chk("accept_first", {31'd0, acc}, 32'd1);
    repeat (3) cycle(0, 0, '0, 0, 1, acc);

    // Swap, with swap_i flipped after acceptance.
    cycle(0, 1, 32'h12345678, 1, 1, acc);
    cycle(0, 0, '0, 0, 1, acc);
    cycle(0, 0, '0, 1, 1, acc);
    cycle(0, 0, '0, 0, 1, acc);

    // Back-to-back words, continuously offered.
    words[0] = 32'h00010002;
    words[1] = 32'h00030004;
    idx = 0;
    for (int i = 0; i < 20 && idx < 2; i++) begin
      cycle(0, 1, words[idx], 0, 1, acc);
      if (acc) idx++;
    end
    chk("b2b_accepted", idx, 2);
    repeat (3) cycle(0, 0, '0, 0, 1, acc);

    // Backpressure in FIRST: v_i offered but must be ignored.
    cycle(0, 1, 32'hCAFEBEEF, 0, 1, acc);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 32'hDEAD0000 + i, 1, 0, acc);
      chk("bp_no_accept", {31'd0, acc}, 32'd0);
    end
    repeat (3) cycle(0, 0, '0, 0, 1, acc);

    // Reset while in SECOND, then a fresh word.
    cycle(0, 1, 32'h55AA33CC, 0, 1, acc);
    cycle(0, 0, '0, 0, 1, acc);
    cycle(1, 0, '0, 0, 0, acc);
    cycle(0, 1, 32'h0BADF00D, 1, 1, acc);
    chk("post_reset_accept", {31'd0, acc}, 32'd1);
    repeat (3) cycle(0, 0, '0, 0, 1, acc);

    // Constrained random traffic with occasional resets.
    hold = 0;
    rw   = '0;
    rs   = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic v, y, r, sx;
      if (!hold) begin
        rw = $urandom;
        rs = 1'($urandom_range(1));
      end
      v  = ($urandom_range(3) != 0);
      y  = ($urandom_range(2) != 0);
      r  = ($urandom_range(63) == 0);
      sx = 1'($urandom_range(1));
      cycle(r, v, rw, v ? rs : sx, y, acc);
      hold = v && !acc;
    end

    // Drain.
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 0, 1, acc);
    @(posedge clk);
    #1;
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bsg_swap_serialize
`default_nettype wire
